// File: rtl/fpu_seq_multiplier_pkg.sv
// fpu_seq_multiplier_pkg: shared state encoding for the sequential multiplier
package fpu_seq_multiplier_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_COMP,
        MUL_DONE
    } fpuMultiplierState_t;

endpackage

// File: rtl/fpu_seq_multiplier_fsm.sv
// fpu_seq_multiplier_fsm: start/done handshake control for the shift-add multiplier
module fpu_seq_multiplier_fsm
    import fpu_seq_multiplier_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic compDone,
    output logic compEn,
    output logic loadEn,
    output logic busy,
    output logic done
);

    fpuMultiplierState_t state, nextState;
    logic                canStart;

    // State register, cleared asynchronously so a mid-operation reset aborts at once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= MUL_IDLE;
        else        state <= nextState;
    end

    // Next state: compute until the last bit, otherwise wait for a start; illegal codes recover to idle
    always_comb begin
        canStart  = (state == MUL_IDLE) || (state == MUL_DONE);
        nextState = (state == MUL_COMP) ? (compDone ? MUL_DONE : MUL_COMP) :
                    canStart            ? (start ? MUL_COMP : state)       : MUL_IDLE;
    end

    // Outputs decoded from the state; a start is only honoured outside MUL_COMP
    always_comb begin
        busy   = (state == MUL_COMP);
        done   = (state == MUL_DONE);
        compEn = busy;
        loadEn = start && canStart;
    end

endmodule

// File: rtl/fpu_seq_multiplier.sv
// fpu_seq_multiplier: unsigned shift-add multiplier, one multiplier bit per clock
module fpu_seq_multiplier
    import fpu_seq_multiplier_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRACW = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   mulIn1,
    input  logic [WIDTH-1:0]   mulIn2,
    output logic [2*WIDTH-1:0] mulOut,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(WIDTH + 1);

    // The fraction width only has to fit inside the mantissa operand
    if (FRACW >= WIDTH) begin : gBadFracw
        $error("FRACW must be smaller than WIDTH");
    end

    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    counter;
    logic [WIDTH:0]   sum;
    logic             compEn, loadEn, compDone;

    fpu_seq_multiplier_fsm uFsm (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .compDone (compDone),
        .compEn   (compEn),
        .loadEn   (loadEn),
        .busy     (busy),
        .done     (done)
    );

    // Partial sum one bit wider than the operand so the carry survives into the shift
    always_comb begin
        sum      = a + {1'b0, q[0] ? m : '0};
        compDone = (counter == CW'(1));
        mulOut   = {a[WIDTH-1:0], q};
    end

    // Datapath: latch operands on start, then add-and-shift once per compute cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m       <= '0;
            a       <= '0;
            q       <= '0;
            counter <= '0;
        end else if (loadEn) begin
            m       <= mulIn1;
            a       <= '0;
            q       <= mulIn2;
            counter <= CW'(WIDTH);
        end else if (compEn) begin
            {a, q}  <= {sum, q} >> 1;
            counter <= counter - CW'(1);
        end
    end

endmodule

// File: tb/tb_fpu_seq_multiplier.sv
// tb_fpu_seq_multiplier: vector table plus corner sequences, scoreboard-checked
module tb_fpu_seq_multiplier;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    logic        clock = 0;
    logic        reset = 0;
    logic        start = 0;
    logic [15:0] mulIn1 = 0;
    logic [15:0] mulIn2 = 0;
    logic [31:0] mulOut;
    logic        busy, done;

    int          total = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    vec_t        vecs[8];

    fpu_seq_multiplier #(.WIDTH(16), .FRACW(10)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .mulIn1 (mulIn1),
        .mulIn2 (mulIn2),
        .mulOut (mulOut),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (busy) cycles++;
            @(negedge clock);
        end
    endtask

    task automatic popCheck(input string name);
        logic [31:0] e;
        total++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", name, mulOut);
        end else begin
            e = sb.pop_front();
            if (mulOut !== e) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", name, mulOut, e);
            end
        end
    endtask

    task automatic doOp(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p, input string name);
        int cycles;
        mulIn1 = a;
        mulIn2 = b;
        start  = 1;
        sb.push_back(p);
        @(negedge clock);
        start  = 0;
        mulIn1 = ~a;
        mulIn2 = ~b;
        check({name, " busy after start"}, {31'd0, busy}, 32'd1);
        check({name, " done after start"}, {31'd0, done}, 32'd0);
        waitDone(cycles);
        check({name, " busy cycles"}, cycles, 32'd16);
        check({name, " done"}, {31'd0, done}, 32'd1);
        check({name, " busy at done"}, {31'd0, busy}, 32'd0);
        popCheck({name, " product"});
    endtask

    initial begin
        int          cycles;
        logic [15:0] ra, rb;
        vecs[0] = '{16'd3,    16'd5,    32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h0000, 16'h1234, 32'h00000000};
        vecs[3] = '{16'h8000, 16'h0002, 32'h00010000};
        vecs[4] = '{16'h1234, 16'h0000, 32'h00000000};
        vecs[5] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
        vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
        vecs[7] = '{16'h00FF, 16'h0100, 32'h0000FF00};

        #2;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset mulOut", mulOut, 32'd0);
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        check("idle busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 8; i++)
            doOp(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

        repeat (3) @(negedge clock);
        check("done held", {31'd0, done}, 32'd1);
        check("product held", mulOut, 32'h0000FF00);
        doOp(16'd100, 16'd200, 32'd20000, "backtoback");

        mulIn1 = 16'd7;
        mulIn2 = 16'd9;
        start  = 1;
        sb.push_back(32'd63);
        @(negedge clock);
        start = 0;
        repeat (4) @(negedge clock);
        mulIn1 = 16'd2;
        mulIn2 = 16'd2;
        start  = 1;
        @(negedge clock);
        start  = 0;
        mulIn1 = 16'hAAAA;
        mulIn2 = 16'h5555;
        waitDone(cycles);
        check("ignored start cycles", cycles, 32'd11);
        check("ignored start done", {31'd0, done}, 32'd1);
        popCheck("ignored start product");

        mulIn1 = 16'hABCD;
        mulIn2 = 16'h1357;
        start  = 1;
        @(negedge clock);
        start = 0;
        repeat (7) @(negedge clock);
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        reset = 0;
        #1;
        check("async reset busy", {31'd0, busy}, 32'd0);
        check("async reset done", {31'd0, done}, 32'd0);
        check("async reset mulOut", mulOut, 32'd0);
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        doOp(16'd6, 16'd7, 32'd42, "after reset");

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            doOp(ra, rb, 32'(ra) * 32'(rb), $sformatf("rand%0d", i));
        end

        check("scoreboard drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", total, errors);
        $finish;
    end

endmodule
